// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit byte buffer.
//   UART_DATA_W : width of one UART character
//   tx_state_e  : launch sequencer states
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    COOLDOWN  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the CPU/transmitter side and uart_tx_fifo.
//   slave  : the buffer (consumes in_*, drives out_*)
//   master : the environment (drives in_*, observes out_*)
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   in_wr_en;
  logic [UART_DATA_W-1:0] in_wr_data;
  logic                   out_full;
  logic                   out_empty;
  logic [CNT_W-1:0]       out_count;
  logic                   out_send_data_en;
  logic [UART_DATA_W-1:0] out_data;
  logic                   in_tx_active;
  logic                   in_tx_done;
  logic                   in_clr_overflow;
  logic                   out_overflow;

  modport slave (
    input  in_wr_en, in_wr_data, in_tx_active, in_tx_done, in_clr_overflow,
    output out_full, out_empty, out_count, out_send_data_en, out_data, out_overflow
  );

  modport master (
    output in_wr_en, in_wr_data, in_tx_active, in_tx_done, in_clr_overflow,
    input  out_full, out_empty, out_count, out_send_data_en, out_data, out_overflow
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO storage: array, read/write pointers, occupancy count, full/empty.
//   clk, rst  : clock, async active-high reset
//   wr_en     : push request; accepted when not full or when popping this cycle
//   wr_data   : byte to push
//   pop       : remove head (caller guarantees not empty)
//   rd_data   : current head byte (combinational view of storage)
//   count     : entries held (registered)
//   full      : count == DEPTH (registered)
//   empty     : count == 0 (registered)
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [UART_DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   push_c;

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_c  = wr_en && (!full_q || pop);
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues CPU bytes and launches them one at a time
// into the transmitter over its send-enable / active / done handshake.
//   clk, rst : clock, async active-high reset
//   bus      : uart_tx_fifo_if.slave (write port, status, launch port,
//              transmitter status, overflow flag and clear)
// Optional feature macro UART_TX_FIFO_OVERFLOW_FLAG_EN: when defined,
// out_overflow is a sticky dropped-write flag cleared by in_clr_overflow;
// otherwise out_overflow is 0 and in_clr_overflow is ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  tx_state_e              state_q, state_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   send_q, send_d;
  logic                   pop_c;
  logic [UART_DATA_W-1:0] head_c;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.in_wr_en),
    .wr_data (bus.in_wr_data),
    .pop     (pop_c),
    .rd_data (head_c),
    .count   (bus.out_count),
    .full    (bus.out_full),
    .empty   (bus.out_empty)
  );

  // Launch sequencer: a new byte goes out only once the transmitter has
  // shown active, then done, then dropped both, so its tail can't re-trigger.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    send_d  = 1'b0;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.out_empty && !bus.in_tx_active && !bus.in_tx_done) begin
          pop_c   = 1'b1;
          data_d  = head_c;
          send_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.in_tx_active) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.in_tx_done) state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (!bus.in_tx_active && !bus.in_tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      send_q  <= send_d;
    end
  end

  assign bus.out_send_data_en = send_q;
  assign bus.out_data         = data_q;

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;
  logic drop_c;

  // Dropped write: full and nothing leaves this edge. Set beats clear.
  assign drop_c = bus.in_wr_en && bus.out_full && !pop_c;

  always_comb begin
    overflow_d = overflow_q;
    if (bus.in_clr_overflow) overflow_d = 1'b0;
    if (drop_c)              overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign bus.out_overflow = overflow_q;
`else
  logic unused_clr_c;
  assign unused_clr_c     = bus.in_clr_overflow;
  assign bus.out_overflow = 1'b0;
`endif

endmodule
